// File: rtl/hmmm_pkg.sv
// Shared constants for the Hmmm core: FSM states, opcodes, function codes, ALU ops.
// Optional build macro: HMMM_MULDIV_EN (enables mul/div/mod).
package hmmm_pkg;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [3:0] OP_SYS    = 4'h0;
  localparam logic [3:0] OP_SETN   = 4'h1;
  localparam logic [3:0] OP_LOADN  = 4'h2;
  localparam logic [3:0] OP_STOREN = 4'h3;
  localparam logic [3:0] OP_MEMR   = 4'h4;
  localparam logic [3:0] OP_ADDN   = 4'h5;
  localparam logic [3:0] OP_ADD    = 4'h6;
  localparam logic [3:0] OP_SUB    = 4'h7;
  localparam logic [3:0] OP_MUL    = 4'h8;
  localparam logic [3:0] OP_DIV    = 4'h9;
  localparam logic [3:0] OP_MOD    = 4'hA;
  localparam logic [3:0] OP_CALLN  = 4'hB;
  localparam logic [3:0] OP_JEQZN  = 4'hC;
  localparam logic [3:0] OP_JNEZN  = 4'hD;
  localparam logic [3:0] OP_JGTZN  = 4'hE;
  localparam logic [3:0] OP_JLTZN  = 4'hF;

  // Function codes in the low nibble of opcode 0000
  localparam logic [3:0] F_READ  = 4'h1;
  localparam logic [3:0] F_WRITE = 4'h2;
  localparam logic [3:0] F_JUMPR = 4'h3;

  // Function codes in the low nibble of opcode 0100
  localparam logic [3:0] F_LOADR  = 4'h0;
  localparam logic [3:0] F_STORER = 4'h1;
  localparam logic [3:0] F_POPR   = 4'h2;
  localparam logic [3:0] F_PUSHR  = 4'h3;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_MUL,
    ALU_DIV,
    ALU_MOD
  } alu_op_e;

  function automatic logic [15:0] sext8(input logic [7:0] n);
    return {{8{n[7]}}, n};
  endfunction

endpackage

// File: rtl/hmmm_alu.sv
// Combinational ALU for the Hmmm core plus sign tests on operand a.
// Multiplier and divider exist only when HMMM_MULDIV_EN is defined.
module hmmm_alu
  import hmmm_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  alu_op_e     op,
  output logic [15:0] y,
  output logic        a_zero,
  output logic        a_neg
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
`ifdef HMMM_MULDIV_EN
      ALU_MUL: y = a * b;
      // Signed division truncates toward zero; a zero divisor yields 0
      ALU_DIV: y = (b == '0) ? '0 : $signed(a) / $signed(b);
      ALU_MOD: y = (b == '0) ? '0 : $signed(a) % $signed(b);
`endif
      default: y = '0;
    endcase
  end

  assign a_zero = (a == '0);
  assign a_neg  = a[15];

endmodule

// File: rtl/hmmm.sv
// Hmmm multicycle CPU: FETCH/EXEC/HALT sequencing, register file, 256x16 memory, shared bus.
// Optional build macro: HMMM_MULDIV_EN (enables mul/div/mod; otherwise they are nops).
module hmmm
  import hmmm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pgrm_addr,
  input  logic        pgrm_data,
  output logic        read,
  output logic        write,
  inout  wire  [15:0] bus,
  output logic        halt
);

  logic [1:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  paddr_q, paddr_d;
  logic [15:0] ir_q, ir_d;
  logic        halt_q, halt_d;
  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];
  logic [15:0] mem [256];

  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_wdata;

  logic        pgrm, exec;
  logic [3:0]  opc, fx, fy, fz;
  logic [7:0]  fn;
  logic [15:0] rx, ry, rz, ry_dec;
  logic [15:0] alu_a, alu_b, alu_y;
  logic        alu_zero, alu_neg;
  alu_op_e     alu_op;

  assign pgrm   = pgrm_addr | pgrm_data;
  assign exec   = (state_q == S_EXEC);
  assign opc    = ir_q[15:12];
  assign fx     = ir_q[11:8];
  assign fy     = ir_q[7:4];
  assign fz     = ir_q[3:0];
  assign fn     = ir_q[7:0];
  assign rx     = regs_q[fx];
  assign ry     = regs_q[fy];
  assign rz     = regs_q[fz];
  assign ry_dec = ry - 16'd1;

  assign read  = exec && (opc == OP_SYS) && (fz == F_READ);
  assign write = exec && (opc == OP_SYS) && (fz == F_WRITE);
  assign bus   = write ? rx : 16'hzzzz;
  assign halt  = halt_q;

  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = ry;
    alu_b  = rz;
    case (opc)
      OP_ADDN: begin
        alu_a = rx;
        alu_b = sext8(fn);
      end
      OP_SUB: alu_op = ALU_SUB;
      OP_MUL: alu_op = ALU_MUL;
      OP_DIV: alu_op = ALU_DIV;
      OP_MOD: alu_op = ALU_MOD;
      OP_JEQZN, OP_JNEZN, OP_JGTZN, OP_JLTZN: alu_a = rx;
      default: ;
    endcase
  end

  hmmm_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .y      (alu_y),
    .a_zero (alu_zero),
    .a_neg  (alu_neg)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred,
  // and blocking '=' is correct because this block describes pure combinational logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    paddr_d   = paddr_q;
    regs_d    = regs_q;
    mem_we    = 1'b0;
    mem_waddr = paddr_q;
    mem_wdata = bus;

    if (pgrm) begin
      // Host programming overrides both reset and the running program
      state_d = S_HALT;
      if (pgrm_addr) paddr_d = bus[7:0];
      mem_we = pgrm_data;
    end else if (rst) begin
      state_d = S_FETCH;
    end else if (state_q == S_FETCH) begin
      ir_d    = mem[pc_q];
      state_d = S_EXEC;
    end else if (exec) begin
      state_d = S_FETCH;
      pc_d    = pc_q + 8'd1;
      case (opc)
        OP_SYS: begin
          if (ir_q == '0) state_d = S_HALT;
          else if (fz == F_READ) regs_d[fx] = bus;
          else if (fz == F_JUMPR) pc_d = rx[7:0];
        end
        OP_SETN:  regs_d[fx] = sext8(fn);
        OP_LOADN: regs_d[fx] = mem[fn];
        OP_STOREN: begin
          mem_we    = 1'b1;
          mem_waddr = fn;
          mem_wdata = rx;
        end
        OP_MEMR: begin
          case (fz)
            F_LOADR: regs_d[fx] = mem[ry[7:0]];
            F_STORER: begin
              mem_we    = 1'b1;
              mem_waddr = ry[7:0];
              mem_wdata = rx;
            end
            // rX is written after rY so it wins when X == Y
            F_POPR: begin
              regs_d[fy] = ry_dec;
              regs_d[fx] = mem[ry_dec[7:0]];
            end
            F_PUSHR: begin
              mem_we     = 1'b1;
              mem_waddr  = ry[7:0];
              mem_wdata  = rx;
              regs_d[fy] = ry + 16'd1;
            end
            default: ;
          endcase
        end
        OP_ADDN, OP_ADD, OP_SUB: regs_d[fx] = alu_y;
`ifdef HMMM_MULDIV_EN
        OP_MUL, OP_DIV, OP_MOD: regs_d[fx] = alu_y;
`endif
        OP_CALLN: begin
          regs_d[fx] = {8'h00, pc_q + 8'd1};
          pc_d       = fn;
        end
        OP_JEQZN: if (alu_zero) pc_d = fn;
        OP_JNEZN: if (!alu_zero) pc_d = fn;
        OP_JGTZN: if (!alu_zero && !alu_neg) pc_d = fn;
        OP_JLTZN: if (alu_neg) pc_d = fn;
        default: ;
      endcase
    end
    regs_d[0] = '0;
  end

  assign halt_d = (state_d == S_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= pgrm ? S_HALT : S_FETCH;
      halt_q  <= pgrm;
      paddr_q <= pgrm_addr ? bus[7:0] : 8'h00;
      pc_q    <= '0;
      ir_q    <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      paddr_q <= paddr_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
    end
  end

  // NOTE: memory has no reset so it maps onto a plain RAM; only the host initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_hmmm.sv
// Self-checking bench for hmmm: ISA-level reference model feeds a write scoreboard.
// Honours HMMM_MULDIV_EN the same way as the design build.
module tb_hmmm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pgrm_addr = 1'b0;
  logic pgrm_data = 1'b0;
  logic read, write, halt;
  wire  [15:0] bus;

  logic        pg_en = 1'b0;
  logic [15:0] pg_val = '0;
  logic [15:0] in_vals [64];
  int          rd_cnt;
  logic        rd_clr = 1'b1;
  logic        mon_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_q [$];
  logic [15:0] prog  [256];
  logic [15:0] m_mem [256];
  logic [15:0] m_reg [16];
  int          m_steps, m_reads;
  bit          m_ok;

  assign bus = read ? in_vals[rd_cnt[5:0]] : (pg_en ? pg_val : 16'hzzzz);

  hmmm dut (
    .clk       (clk),
    .rst       (rst),
    .pgrm_addr (pgrm_addr),
    .pgrm_data (pgrm_data),
    .read      (read),
    .write     (write),
    .bus       (bus),
    .halt      (halt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_clr) rd_cnt <= 0;
    else if (read) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write cycle must match the next expected output word
  always @(negedge clk) begin
    if (mon_en && write) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got %0h expected no write", bus);
      end else begin
        check("write_bus", bus, exp_q.pop_front());
      end
    end
  end

  task automatic setr(input logic [3:0] r, input logic [15:0] v);
    if (r != 4'd0) m_reg[r] = v;
  endtask

  // Instruction-level interpreter of the ISA; pushes expected output words
  task automatic model_run();
    logic [7:0]  pc, nxt, pa;
    logic [15:0] i, rx, ry, rz;
    logic [3:0]  x, y, z;
    int sa, sb;
    for (int r = 0; r < 16; r++) m_reg[r] = '0;
    pc = '0; m_steps = 0; m_reads = 0; m_ok = 0;
    exp_q.delete();
    while (m_steps < 400 && !m_ok) begin
      i = m_mem[pc];
      m_steps++;
      x = i[11:8]; y = i[7:4]; z = i[3:0];
      rx = m_reg[x]; ry = m_reg[y]; rz = m_reg[z];
      sa = int'($signed(ry)); sb = int'($signed(rz));
      nxt = pc + 8'd1;
      case (i[15:12])
        4'h0: begin
          if (i == 16'h0) m_ok = 1;
          else if (z == 4'd1) begin setr(x, in_vals[m_reads % 64]); m_reads++; end
          else if (z == 4'd2) exp_q.push_back(rx);
          else if (z == 4'd3) nxt = rx[7:0];
        end
        4'h1: setr(x, 16'($signed(i[7:0])));
        4'h2: setr(x, m_mem[i[7:0]]);
        4'h3: m_mem[i[7:0]] = rx;
        4'h4: begin
          pa = ry[7:0] - 8'd1;
          case (z)
            4'd0: setr(x, m_mem[ry[7:0]]);
            4'd1: m_mem[ry[7:0]] = rx;
            4'd2: begin setr(y, ry - 16'd1); setr(x, m_mem[pa]); end
            4'd3: begin m_mem[ry[7:0]] = rx; setr(y, ry + 16'd1); end
            default: ;
          endcase
        end
        4'h5: setr(x, rx + 16'($signed(i[7:0])));
        4'h6: setr(x, ry + rz);
        4'h7: setr(x, ry - rz);
`ifdef HMMM_MULDIV_EN
        4'h8: setr(x, 16'(sa * sb));
        4'h9: setr(x, (sb == 0) ? 16'h0 : 16'(sa / sb));
        4'hA: setr(x, (sb == 0) ? 16'h0 : 16'(sa % sb));
`endif
        4'hB: begin setr(x, {8'h00, nxt}); nxt = i[7:0]; end
        4'hC: if (rx == 16'h0) nxt = i[7:0];
        4'hD: if (rx != 16'h0) nxt = i[7:0];
        4'hE: if ($signed(rx) > 0) nxt = i[7:0];
        4'hF: if ($signed(rx) < 0) nxt = i[7:0];
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  task automatic prog_word(input logic [7:0] a, input logic [15:0] w);
    @(negedge clk);
    pgrm_data = 1'b0; pg_en = 1'b1; pg_val = {8'h00, a}; pgrm_addr = 1'b1;
    @(negedge clk);
    pgrm_addr = 1'b0; pgrm_data = 1'b1; pg_val = w;
  endtask

  task automatic load_dut();
    for (int a = 0; a < 256; a++) prog_word(8'(a), prog[a]);
    @(negedge clk);
    pgrm_data = 1'b0; pg_en = 1'b0;
    check("halt_after_load", halt, 1);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++) prog[a] = 16'($urandom);
    for (int k = 0; k < 64; k++) in_vals[k] = 16'($urandom);
  endtask

  task automatic start_dut();
    rd_clr = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; rd_clr = 1'b0;
    check("reset_halt", halt, 0);
    check("reset_read", read, 0);
    check("reset_write", write, 0);
  endtask

  task automatic run_case(input string name);
    int cyc;
    m_mem = prog;
    model_run();
    load_dut();
    start_dut();
    cyc = 0;
    while (!halt && cyc < 1000) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    check({name, "_cycles"}, cyc, 2 * m_steps);
    check({name, "_pending_writes"}, exp_q.size(), 0);
    check({name, "_reads"}, rd_cnt, m_reads);
  endtask

  function automatic logic [15:0] rand_instr(input int p, input int len);
    logic [3:0] x, y, z;
    logic [7:0] n;
    int k, tgt;
    x = 4'($urandom); y = 4'($urandom); z = 4'($urandom); n = 8'($urandom);
    k = $urandom_range(13, 0);
    case (k)
      0:  return {4'h1, x, n};
      1:  return {4'h5, x, n};
      2:  return {4'h6, x, y, z};
      3:  return {4'h7, x, y, z};
      4:  return {4'h8, x, y, z};
      5:  return {4'h9, x, y, z};
      6:  return {4'hA, x, y, z};
      7:  return {4'h0, x, 8'h01};
      8:  return {4'h0, x, 8'h02};
      9:  return {4'h2, x, 1'b1, n[6:0]};
      10: return {4'h3, x, 1'b1, n[6:0]};
      11: return {4'h4, x, y, 2'b00, z[1:0]};
      12: return n[0] ? {4'h0, x, y, z | 4'h4} : {4'h4, x, y, z | 4'h4};
      default: begin
        tgt = p + 1 + int'(n[1:0]);
        if (tgt > len) tgt = len;
        return {4'hC + {2'b00, z[1:0]}, x, 8'(tgt)};
      end
    endcase
  endfunction

  task automatic gen_random();
    int len;
    fill_random();
    len = $urandom_range(24, 8);
    for (int p = 0; p < len; p++) prog[p] = rand_instr(p, len);
    for (int r = 1; r < 16; r++) prog[len + r - 1] = {4'h0, 4'(r), 8'h02};
    prog[len + 15] = 16'h0000;
  endtask

  initial begin
    // Reset together with a programming pulse must land in HALT
    for (int k = 0; k < 64; k++) in_vals[k] = 16'($urandom);
    @(negedge clk);
    pg_en = 1'b1; pg_val = 16'h0000; pgrm_addr = 1'b1; rst = 1'b1;
    @(negedge clk);
    pgrm_addr = 1'b0; rst = 1'b0; pg_en = 1'b0;
    check("halt_rst_with_pgm", halt, 1);
    mon_en = 1'b1;

    // setn r1 42; write r1; halt
    fill_random();
    prog[0] = 16'h112A; prog[1] = 16'h0102; prog[2] = 16'h0000;
    run_case("setn_write");

    // read r2 from host, write it back
    fill_random();
    in_vals[0] = 16'hBEEF;
    prog[0] = 16'h0201; prog[1] = 16'h0202; prog[2] = 16'h0000;
    run_case("read_write");

    // -1 + -1, then division by r0
    fill_random();
    prog[0] = 16'h11FF; prog[1] = 16'h12FF; prog[2] = 16'h6312; prog[3] = 16'h0302;
    prog[4] = 16'h9310; prog[5] = 16'h0302; prog[6] = 16'h0000;
    run_case("add_div0");

    // calln / jumpr return, jeqzn taken, jnezn not taken
    fill_random();
    prog[0] = 16'h1105; prog[1] = 16'hBE10; prog[2] = 16'h0E02; prog[3] = 16'h1100;
    prog[4] = 16'hC106; prog[5] = 16'h0000; prog[6] = 16'hD108; prog[7] = 16'h0102;
    prog[8] = 16'h0000; prog[16] = 16'h0102; prog[17] = 16'h0E03;
    run_case("call_jump");

    // pushr r1 r15 / popr r2 r15, then X==Y variants
    fill_random();
    prog[0] = 16'h1177; prog[1] = 16'h1FC0; prog[2] = 16'h41F3; prog[3] = 16'h42F2;
    prog[4] = 16'h0202; prog[5] = 16'h0F02; prog[6] = 16'h15A0; prog[7] = 16'h4553;
    prog[8] = 16'h0502; prog[9] = 16'h16A1; prog[10] = 16'h4662; prog[11] = 16'h0602;
    prog[12] = 16'h0000;
    run_case("push_pop");

    // Programming pulse while a loop is running freezes the core
    fill_random();
    prog[0] = 16'h5101; prog[1] = 16'hB000;
    exp_q.delete();
    load_dut();
    start_dut();
    repeat (15) @(negedge clk);
    check("running_before_pulse", halt, 0);
    pg_en = 1'b1; pg_val = 16'h0000; pgrm_addr = 1'b1;
    @(negedge clk);
    pgrm_addr = 1'b0; pg_en = 1'b0;
    check("halt_after_pulse", halt, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("frozen_halt", halt, 1);
      check("frozen_bus_idle", {read, write}, 2'b00);
    end

    // Randomised programs checked against the interpreter
    for (int t = 0; t < 16; t++) begin
      int tries = 0;
      do begin
        gen_random();
        m_mem = prog;
        model_run();
        tries++;
      end while (!m_ok && tries < 50);
      run_case($sformatf("random%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
